// File: rtl/fw_stream_framer.sv
// Frames a beat stream into DIM x DIM matrices, tags row/beat/sof/eof, optional zero->inf substitution.
// Latency: 1 cycle from accept to head of the output buffer.
// Backpressure: in_ready drops when the buffer is full; inhibit holds the head beat stable.

module fw_stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
endmodule

module fw_stream_framer #(
    parameter int ELEM_W     = 16,
    parameter int LANES      = 4,
    parameter int DIM        = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int DW        = LANES * ELEM_W,
    localparam int BEATS     = DIM / LANES,
    localparam int ROW_W     = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     inD,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inf_en,
    input  logic              flush,
    input  logic              inhibit,
    output logic [DW-1:0]     outD,
    output logic              out_valid,
    output logic [ROW_W-1:0]  row_idx,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              sof,
    output logic              eof,
    output logic [7:0]        frame_cnt
);
    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BEAT_W-1:0] beat;
        logic              sof;
        logic              eof;
        logic [DW-1:0]     dat;
    } beat_t;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    logic [ROW_W-1:0]  row_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    beat_t             wr_beat;
    beat_t             head;

    assign in_ready  = !reset && !fifo_full;
    assign out_valid = !reset && !fifo_empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && !inhibit;

    // Off-diagonal zeros mean "no edge"; store them as all-ones (infinity).
    always_comb begin
        wr_beat      = '0;
        wr_beat.row  = row_cnt;
        wr_beat.beat = beat_cnt;
        wr_beat.sof  = (row_cnt == '0) && (beat_cnt == '0);
        wr_beat.eof  = (row_cnt == ROW_LAST) && (beat_cnt == BEAT_LAST);
        wr_beat.dat  = inD;
        for (int l = 0; l < LANES; l++) begin
            if (inf_en && (inD[l*ELEM_W +: ELEM_W] == '0) &&
                ((int'(beat_cnt) * LANES + l) != int'(row_cnt))) begin
                wr_beat.dat[l*ELEM_W +: ELEM_W] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            row_cnt  <= '0;
            beat_cnt <= '0;
        end else if (push) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                row_cnt  <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) frame_cnt <= '0;
        else if (pop && head.eof) frame_cnt <= frame_cnt + 8'd1;
    end

    fw_stream_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .push     (push),
        .push_dat (wr_beat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign outD     = out_valid ? head.dat  : '0;
    assign row_idx  = out_valid ? head.row  : '0;
    assign beat_idx = out_valid ? head.beat : '0;
    assign sof      = out_valid && head.sof;
    assign eof      = out_valid && head.eof;
endmodule
